// File: rtl/pwm_ramp_sequencer_pkg.sv
// Shared definitions for the PWM ramp sequencer: state encoding and
// default widths of the period counter/duty and the hold field.
package pwm_ramp_sequencer_pkg;

  localparam int DATA_DEFAULT   = 4;
  localparam int HOLD_W_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter (period = 2^DATA clocks) with a
// period_tick flag on the last count, shared by PWM blocks.
module pwm_period_counter
  import pwm_ramp_sequencer_pkg::*;
#(
  parameter int DATA = DATA_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic [DATA-1:0] counter,
  output logic            period_tick
);

  logic [DATA-1:0] counter_q;
  logic [DATA-1:0] counter_d;

  // Natural binary overflow provides the 2^DATA-1 -> 0 wrap.
  always_comb begin
    counter_d = counter_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter_q <= '0;
    end else begin
      counter_q <= counter_d;
    end
  end

  assign counter     = counter_q;
  assign period_tick = &counter_q;

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// PWM duty sequencer: ramps duty toward a loaded target, changing it only on
// period boundaries. Define PWM_RAMP_EN for stepped ramps; otherwise duty jumps.
module pwm_ramp_sequencer
  import pwm_ramp_sequencer_pkg::*;
#(
  parameter int DATA   = DATA_DEFAULT,
  parameter int HOLD_W = HOLD_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA-1:0]   target,
  input  logic [HOLD_W-1:0] hold,
  output logic              ack,
  output logic              busy,
  output logic              done,
  output logic [DATA-1:0]   counter,
  output logic [DATA-1:0]   duty,
  output logic              period_tick
);

  state_e          state_q, state_d;
  logic [DATA-1:0] duty_q, duty_d;
  logic [DATA-1:0] target_q, target_d;
  logic            ack_q, ack_d;
  logic            done_q, done_d;

  pwm_period_counter #(.DATA(DATA)) u_period_counter (
    .clk         (clk),
    .rst         (rst),
    .counter     (counter),
    .period_tick (period_tick)
  );

`ifdef PWM_RAMP_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
      hcnt_q <= '0;
    end else begin
      hold_q <= hold_d;
      hcnt_q <= hcnt_d;
    end
  end
`else
  logic unused_hold;
  assign unused_hold = ^hold;
`endif

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    ack_d    = 1'b0;
    done_d   = 1'b0;
`ifdef PWM_RAMP_EN
    hold_d   = hold_q;
    hcnt_d   = hcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          target_d = target;
`ifdef PWM_RAMP_EN
          hold_d   = hold;
          hcnt_d   = '0;
`endif
          ack_d    = 1'b1;
          state_d  = RAMP;
        end
      end
      RAMP: begin
        // Duty only moves on the wrap edge so each period sees one value.
        if (period_tick) begin
`ifdef PWM_RAMP_EN
          if (duty_q == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (hcnt_q == hold_q) begin
            hcnt_d = '0;
            duty_d = (target_q > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;
            if (duty_d == target_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
`else
          duty_d  = target_q;
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
    end
  end

  assign ack  = ack_q;
  assign done = done_q;
  assign busy = (state_q == RAMP);
  assign duty = duty_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer; follows PWM_RAMP_EN to pick
// the stepped-ramp or direct-jump expectations.
module tb_pwm_ramp_sequencer;

  localparam int DATA   = 4;
  localparam int HOLD_W = 4;
  localparam int PER    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load = 1'b0;
  logic [DATA-1:0]   target = '0;
  logic [HOLD_W-1:0] hold = '0;
  logic              ack, busy, done, period_tick;
  logic [DATA-1:0]   counter, duty;

  always #5 clk = ~clk;

  pwm_ramp_sequencer #(.DATA(DATA), .HOLD_W(HOLD_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .target      (target),
    .hold        (hold),
    .ack         (ack),
    .busy        (busy),
    .done        (done),
    .counter     (counter),
    .duty        (duty),
    .period_tick (period_tick)
  );

  typedef struct {
    int gap;
    int tgt;
    int hld;
    int exp_final;
    int exp_periods;
  } vec_t;

  vec_t vecs[7];

  int passed = 0;
  int total  = 0;

  // Reference: one accepted ramp described by its start, target, hold and
  // acceptance cycle; everything else follows from period arithmetic.
  int cyc = 0;
  bit m_active = 1'b0;
  int m_duty0 = 0, m_tgt = 0, m_hold = 0, m_cl = 0, m_c1 = 0, m_n = 0, m_cend = 0;
  bit want_load = 1'b0;
  int want_t = 0, want_h = 0;
  bit drop_next = 1'b0;
  bit spur = 1'b0;
  int meas = 0;

  function automatic int exp_duty(int c);
    int ticks;
`ifdef PWM_RAMP_EN
    int d, steps;
`endif
    if (!m_active || c <= m_cl) return m_duty0;
    ticks = (c > m_c1) ? ((c - 1 - m_c1) / PER + 1) : 0;
    if (ticks > m_n) ticks = m_n;
`ifdef PWM_RAMP_EN
    d = (m_tgt > m_duty0) ? m_tgt - m_duty0 : m_duty0 - m_tgt;
    steps = ticks / (m_hold + 1);
    if (steps > d) steps = d;
    return (m_tgt >= m_duty0) ? m_duty0 + steps : m_duty0 - steps;
`else
    return (ticks >= 1) ? m_tgt : m_duty0;
`endif
  endfunction

  function automatic bit m_busy(int c);
    return m_active && (c > m_cl) && (c <= m_cend);
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
  endtask

  task automatic accept();
    int d;
    m_duty0 = exp_duty(cyc);
    m_tgt   = int'(target);
    m_hold  = int'(hold);
    m_cl    = cyc;
    m_c1    = cyc + 1 + (PER - 1 - ((cyc + 1) % PER));
    d = (m_tgt > m_duty0) ? m_tgt - m_duty0 : m_duty0 - m_tgt;
`ifdef PWM_RAMP_EN
    m_n = (d == 0) ? 1 : d * (m_hold + 1);
`else
    m_n = 1;
`endif
    m_cend    = m_c1 + PER * (m_n - 1);
    m_active  = 1'b1;
    want_load = 1'b0;
    drop_next = 1'b1;
    meas      = 0;
    $display("load accepted: cycle %0d duty %0d -> target %0d hold %0d, %0d periods", cyc, m_duty0, m_tgt, m_hold, m_n);
  endtask

  // Check this cycle's outputs, drive the inputs sampled at its closing edge.
  task automatic cycle();
    chk("counter", int'(counter), cyc % PER);
    chk("period_tick", int'(period_tick), int'((cyc % PER) == PER - 1));
    chk("duty", int'(duty), exp_duty(cyc));
    chk("busy", int'(busy), int'(m_busy(cyc)));
    chk("ack", int'(ack), int'(m_active && cyc == m_cl + 1));
    chk("done", int'(done), int'(m_active && cyc == m_cend + 1));
    if (busy && period_tick) meas++;
    if (drop_next) begin
      load = 1'b0;
      drop_next = 1'b0;
    end else if (want_load) begin
      load   = 1'b1;
      target = want_t[DATA-1:0];
      hold   = want_h[HOLD_W-1:0];
    end else if (spur && m_busy(cyc)) begin
      load   = 1'b1;
      target = 4'd2;
      hold   = 4'd0;
    end else begin
      load = 1'b0;
      if (m_busy(cyc)) begin
        target = 4'($urandom_range(0, 15));
        hold   = 4'($urandom_range(0, 15));
      end
    end
    if (load && !m_busy(cyc)) accept();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_ramp(int t, int h);
    want_load = 1'b1;
    want_t = t;
    want_h = h;
    for (int k = 0; k < 4000 && (want_load || cyc <= m_cend); k++) cycle();
  endtask

  task automatic release_reset();
    rst = 1'b1;
    cyc = 0;
    m_active = 1'b0;
    m_duty0 = 0;
    load = 1'b0;
    want_load = 1'b0;
    drop_next = 1'b0;
    spur = 1'b0;
  endtask

  initial begin
`ifdef PWM_RAMP_EN
    vecs[0] = '{3, 3, 0, 3, 3};
    vecs[1] = '{0, 1, 2, 1, 6};
    vecs[2] = '{5, 1, 5, 1, 1};
    vecs[3] = '{0, 9, 0, 9, 8};
    vecs[4] = '{7, 0, 1, 0, 18};
    vecs[5] = '{2, 15, 0, 15, 15};
    vecs[6] = '{0, 15, 3, 15, 1};
`else
    vecs[0] = '{3, 3, 0, 3, 1};
    vecs[1] = '{0, 1, 2, 1, 1};
    vecs[2] = '{5, 1, 5, 1, 1};
    vecs[3] = '{0, 9, 0, 9, 1};
    vecs[4] = '{7, 0, 1, 0, 1};
    vecs[5] = '{2, 15, 0, 15, 1};
    vecs[6] = '{0, 15, 3, 15, 1};
`endif

    repeat (3) @(negedge clk);
    chk("reset counter", int'(counter), 0);
    chk("reset duty", int'(duty), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset ack", int'(ack), 0);
    chk("reset done", int'(done), 0);
    release_reset();
    repeat (40) cycle();

    foreach (vecs[i]) begin
      repeat (vecs[i].gap) cycle();
      run_ramp(vecs[i].tgt, vecs[i].hld);
      chk($sformatf("vec%0d final duty", i), int'(duty), vecs[i].exp_final);
      chk($sformatf("vec%0d periods", i), meas, vecs[i].exp_periods);
    end

    // Loads while busy must be ignored and must not disturb the target.
    want_load = 1'b1;
    want_t = 4;
    want_h = 0;
    cycle();
    cycle();
    spur = 1'b1;
    repeat (20) cycle();
    spur = 1'b0;
    for (int k = 0; k < 4000 && cyc <= m_cend; k++) cycle();
    chk("busy-load final duty", int'(duty), 4);

    // Asynchronous reset mid-ramp.
    want_load = 1'b1;
    want_t = 12;
    want_h = 1;
    repeat (40) cycle();
    #2 rst = 1'b0;
    #1;
    chk("midreset counter", int'(counter), 0);
    chk("midreset duty", int'(duty), 0);
    chk("midreset busy", int'(busy), 0);
    chk("midreset done", int'(done), 0);
    repeat (2) begin
      @(negedge clk);
      chk("midreset hold done", int'(done), 0);
      chk("midreset hold duty", int'(duty), 0);
    end
    release_reset();
    repeat (20) cycle();

    for (int r = 0; r < 8; r++) begin
      int t, h;
      t = int'($urandom_range(0, 15));
      h = int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 20)) cycle();
      run_ramp(t, h);
      chk($sformatf("rand%0d final duty", r), int'(duty), t);
    end
    repeat (20) cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_sequencer.md
# pwm_ramp_sequencer

Sequencer for the PWM comparator datapath. It generates the free-running period counter that feeds the comparator and owns the duty value presented to it. On a load handshake it moves the duty from its current value to a requested target: one LSB step per programmable number of PWM periods. Every duty change lands exactly on a period boundary, so the comparator never sees a glitched period. It sits between the switch/host front end and the comparator/7-segment stage.

## Interface
- DATA, 4, width of period counter and duty; period = 2^DATA clocks
- HOLD_W, 4, width of the hold (periods-per-step) field
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- load  in  1  request to start a new ramp; held by requester until ack
- target  in  DATA  requested final duty, sampled when load is accepted
- hold  in  HOLD_W  extra periods per step, sampled with target (0 = step every period)
- ack  out  1  one-cycle pulse: load accepted
- busy  out  1  ramp in progress
- done  out  1  one-cycle pulse: duty has reached target
- counter  out  DATA  period counter to comparator
- duty  out  DATA  current duty to comparator
- period_tick  out  1  high while counter == 2^DATA-1

## Operation
- Reset (rst low, async): counter=0, duty=0, state IDLE, ack=busy=done=0; internal hold count=0.
- Counter: increments every clk and wraps 2^DATA-1 -> 0 with no stall. period_tick is combinational from counter.
- FSM states:
  - IDLE:
    - load=1 -> latch target/hold, hold count=0, go RAMP.
    - ack=1 on the next cycle.
  - RAMP: busy=1; load ignored (no ack). Evaluated only on period_tick cycles:
    - duty==target: go IDLE, done=1 next cycle, duty unchanged.
    - else if hold count==latched hold: hold count=0, duty +1 if target>duty, else -1. If the new duty equals target, go IDLE on the same edge and assert done next cycle.
    - else: hold count +1.
- Duty arithmetic is unsigned and saturating by construction: a step never passes target, so it never wraps.
- target and hold changes while busy have no effect until the next accepted load.
- Reset asserted mid-ramp aborts immediately; duty returns to 0 and there is no done pulse.

## Timing
- load to ack: 1 cycle. ack and busy rise in the same cycle.
- duty registers on the edge where counter wraps to 0, so each PWM period uses a single duty value.
- Ramp length: |target - duty0| × (hold+1) periods, plus the wait to the first period_tick.
- done and busy falling occur in the cycle after the final duty update, i.e. while counter==0.
- load asserted in the cycle done is high is accepted: IDLE is already active.

## Configuration
- PWM_RAMP_EN defined: stepped ramp as above.
- PWM_RAMP_EN undefined:
  - hold is ignored and the hold counter is not built.
  - At the first period_tick after acceptance, duty <= target, the FSM returns to IDLE, and done pulses next cycle.
  - Handshake is unchanged.

## Structure
- Shared package/include: state encoding constants (IDLE, RAMP), DATA default, HOLD_W default.
- Sub-module pwm_period_counter: the counter plus period_tick generation, reusable by other PWM blocks.

## Test plan
- Reset release, DATA=4 -> counter cycles 0..15, period_tick every 16 clocks at 15, duty=0, busy=0.
- From duty 0, load target=3 hold=0 -> ack 1 cycle later; duty 1,2,3 at the next three wraps; done pulse at counter 0 of the period with duty 3; busy then 0.
- From duty 3, load target=1 hold=2 -> duty 2 after 3 periods, duty 1 after 6; done once.
- load while busy -> no ack, target unchanged. load with target==duty -> done at the cycle after the next period_tick, duty constant.
- rst low mid-ramp at duty 2 -> duty=0, busy=0, counter=0 immediately, no done.
- PWM_RAMP_EN undefined, load target=9 from 0 -> duty jumps to 9 at the next wrap, done the following cycle.
